l2_noc1_req_driver: RTL and testbench

//  Upstream stimulus stage for the L2 refinement harness. Accepts one abstract

---
 rtl/l2_noc_pkg.sv | 78 +++++++
 rtl/noc_flit_hdr_pack.sv | 27 ++
 rtl/l2_noc1_req_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_l2_noc1_req_driver.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_noc_pkg.sv
// NoC1 request driver shared definitions.
// Flit layout, message types, FSM states and header builders.
package l2_noc_pkg;

  localparam int FLIT_W      = 64;
  localparam int MAX_DATA    = 2;
  localparam int STALL_LIMIT = 64;

  localparam int H1_CHIP_MSB = 63;
  localparam int H1_CHIP_LSB = 50;
  localparam int H1_X_MSB    = 49;
  localparam int H1_X_LSB    = 42;
  localparam int H1_Y_MSB    = 41;
  localparam int H1_Y_LSB    = 34;
  localparam int H1_PLEN_MSB = 29;
  localparam int H1_PLEN_LSB = 22;
  localparam int H1_TYPE_MSB = 21;
  localparam int H1_TYPE_LSB = 14;
  localparam int H1_MSHR_MSB = 13;
  localparam int H1_MSHR_LSB = 6;
  localparam int H2_ADDR_MSB = 55;
  localparam int H2_ADDR_LSB = 16;

  localparam logic [7:0] MSG_STORE_REQ    = 8'd2;
  localparam logic [7:0] MSG_NC_LOAD_REQ  = 8'd14;
  localparam logic [7:0] MSG_NC_STORE_REQ = 8'd15;
  localparam logic [7:0] MSG_LOAD_REQ     = 8'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_DATA
  } drv_state_t;

  function automatic logic [FLIT_W-1:0] pack_hdr1(
    input logic [13:0] chipid,
    input logic [7:0]  x,
    input logic [7:0]  y,
    input logic [7:0]  paylen,
    input logic [7:0]  mtype,
    input logic [7:0]  mshrid
  );
    logic [FLIT_W-1:0] h;
    h = '0;
    h[H1_CHIP_MSB:H1_CHIP_LSB] = chipid;
    h[H1_X_MSB:H1_X_LSB]       = x;
    h[H1_Y_MSB:H1_Y_LSB]       = y;
    h[H1_PLEN_MSB:H1_PLEN_LSB] = paylen;
    h[H1_TYPE_MSB:H1_TYPE_LSB] = mtype;
    h[H1_MSHR_MSB:H1_MSHR_LSB] = mshrid;
    return h;
  endfunction

  function automatic logic [FLIT_W-1:0] pack_hdr2(
    input logic [39:0] addr
  );
    logic [FLIT_W-1:0] h;
    h = '0;
    h[H2_ADDR_MSB:H2_ADDR_LSB] = addr;
    return h;
  endfunction

  function automatic logic [FLIT_W-1:0] pack_hdr3(
    input logic [13:0] chipid,
    input logic [7:0]  x,
    input logic [7:0]  y
  );
    logic [FLIT_W-1:0] h;
    h = '0;
    h[H1_CHIP_MSB:H1_CHIP_LSB] = chipid;
    h[H1_X_MSB:H1_X_LSB]       = x;
    h[H1_Y_MSB:H1_Y_LSB]       = y;
    return h;
  endfunction

endpackage

// File: rtl/noc_flit_hdr_pack.sv
// Combinational builder for the three NoC1 header flits.
// Payload length counts the two trailing headers plus data flits.
module noc_flit_hdr_pack
  import l2_noc_pkg::*;
(
  input  logic [13:0]       i_chipid,
  input  logic [7:0]        i_x,
  input  logic [7:0]        i_y,
  input  logic [1:0]        i_dcnt,
  input  logic [7:0]        i_type,
  input  logic [7:0]        i_mshrid,
  input  logic [39:0]       i_addr,
  output logic [FLIT_W-1:0] o_hdr1,
  output logic [FLIT_W-1:0] o_hdr2,
  output logic [FLIT_W-1:0] o_hdr3
);

  logic [7:0] w_paylen;

  assign w_paylen = 8'd2 + {6'd0, i_dcnt};

  assign o_hdr1 = pack_hdr1(i_chipid, i_x, i_y,
                            w_paylen, i_type, i_mshrid);
  assign o_hdr2 = pack_hdr2(i_addr);
  assign o_hdr3 = pack_hdr3(i_chipid, i_x, i_y);

endmodule

// File: rtl/l2_noc1_req_driver.sv
// Serializes one abstract L2 request into NoC1 flits
// and mirrors it onto the ILA msg1 inputs.
module l2_noc1_req_driver
  import l2_noc_pkg::*;
#(
  parameter int MAX_DATA_P    = MAX_DATA,
  parameter int STALL_LIMIT_P = STALL_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_type,
  input  logic [39:0]       req_addr,
  input  logic [7:0]        req_mshrid,
  input  logic [5:0]        req_src,
  input  logic [1:0]        req_dcnt,
  input  logic [63:0]       req_data0,
  input  logic [63:0]       req_data1,
  input  logic [13:0]       chipid,
  input  logic [7:0]        coreid_x,
  input  logic [7:0]        coreid_y,
  output logic              noc1_valid,
  output logic [FLIT_W-1:0] noc1_data,
  input  logic              noc1_ready,
  output logic              ila_msg1_valid,
  output logic [7:0]        ila_msg1_type,
  output logic [25:0]       ila_msg1_tag,
  output logic [5:0]        ila_msg1_source,
  output logic [63:0]       ila_msg1_data,
  output logic              issue,
  output logic              done,
  output logic              busy,
  output logic              stall_err
);

  localparam int SW = $clog2(STALL_LIMIT_P + 1);

  drv_state_t        r_state;
  logic [7:0]        r_type;
  logic [39:0]       r_addr;
  logic [7:0]        r_mshrid;
  logic [5:0]        r_src;
  logic [1:0]        r_dcnt;
  logic [63:0]       r_data0;
  logic [63:0]       r_data1;
  logic [13:0]       r_chipid;
  logic [7:0]        r_x;
  logic [7:0]        r_y;
  logic [1:0]        r_didx;
  logic              r_noc1_valid;
  logic [FLIT_W-1:0] r_noc1_data;
  logic              r_req_ready;
  logic              r_ila_valid;
  logic              r_issue;
  logic [SW-1:0]     r_stall_cnt;
  logic              r_stall_err;

  logic              w_idle;
  logic              w_hs;
  logic              w_last;
  logic [1:0]        w_dcnt_in;
  logic [13:0]       w_chipid;
  logic [7:0]        w_x;
  logic [7:0]        w_y;
  logic [1:0]        w_dcnt;
  logic [7:0]        w_type;
  logic [7:0]        w_mshrid;
  logic [FLIT_W-1:0] w_hdr1;
  logic [FLIT_W-1:0] w_hdr2;
  logic [FLIT_W-1:0] w_hdr3;

  assign w_idle = (r_state == ST_IDLE);
  assign w_hs   = r_noc1_valid && noc1_ready;

  assign w_dcnt_in = (req_dcnt > 2'(MAX_DATA_P))
                   ? 2'(MAX_DATA_P) : req_dcnt;

  // HDR1 is loaded on the accept edge, before fields are latched.
  assign w_chipid = w_idle ? chipid     : r_chipid;
  assign w_x      = w_idle ? coreid_x   : r_x;
  assign w_y      = w_idle ? coreid_y   : r_y;
  assign w_dcnt   = w_idle ? w_dcnt_in  : r_dcnt;
  assign w_type   = w_idle ? req_type   : r_type;
  assign w_mshrid = w_idle ? req_mshrid : r_mshrid;

  noc_flit_hdr_pack u_hdr_pack (
    .i_chipid (w_chipid),
    .i_x      (w_x),
    .i_y      (w_y),
    .i_dcnt   (w_dcnt),
    .i_type   (w_type),
    .i_mshrid (w_mshrid),
    .i_addr   (r_addr),
    .o_hdr1   (w_hdr1),
    .o_hdr2   (w_hdr2),
    .o_hdr3   (w_hdr3)
  );

  assign w_last = ((r_state == ST_HDR3) && (r_dcnt == 2'd0))
               || ((r_state == ST_DATA)
                   && (r_didx == r_dcnt - 2'd1));

  // FSM, flit register, ILA mirror and stall watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_type       <= '0;
      r_addr       <= '0;
      r_mshrid     <= '0;
      r_src        <= '0;
      r_dcnt       <= '0;
      r_data0      <= '0;
      r_data1      <= '0;
      r_chipid     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_didx       <= '0;
      r_noc1_valid <= 1'b0;
      r_noc1_data  <= '0;
      r_req_ready  <= 1'b1;
      r_ila_valid  <= 1'b0;
      r_issue      <= 1'b0;
      r_stall_cnt  <= '0;
      r_stall_err  <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_type       <= req_type;
            r_addr       <= req_addr;
            r_mshrid     <= req_mshrid;
            r_src        <= req_src;
            r_dcnt       <= w_dcnt_in;
            r_data0      <= req_data0;
            r_data1      <= req_data1;
            r_chipid     <= chipid;
            r_x          <= coreid_x;
            r_y          <= coreid_y;
            r_didx       <= '0;
            r_noc1_valid <= 1'b1;
            r_noc1_data  <= w_hdr1;
            r_req_ready  <= 1'b0;
            r_ila_valid  <= 1'b1;
            r_state      <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_hs) begin
            r_issue     <= 1'b1;
            r_noc1_data <= w_hdr2;
            r_state     <= ST_HDR2;
          end
        end
        ST_HDR2: begin
          if (w_hs) begin
            r_noc1_data <= w_hdr3;
            r_state     <= ST_HDR3;
          end
        end
        ST_HDR3: begin
          if (w_hs) begin
            if (w_last) begin
              r_noc1_valid <= 1'b0;
              r_noc1_data  <= '0;
              r_req_ready  <= 1'b1;
              r_ila_valid  <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_didx      <= '0;
              r_noc1_data <= r_data0;
              r_state     <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            if (w_last) begin
              r_noc1_valid <= 1'b0;
              r_noc1_data  <= '0;
              r_req_ready  <= 1'b1;
              r_ila_valid  <= 1'b0;
              r_state      <= ST_IDLE;
            end else begin
              r_didx      <= r_didx + 2'd1;
              r_noc1_data <= r_data1;
            end
          end
        end
        default: begin
          r_noc1_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_ila_valid  <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase

      if (w_hs) begin
        r_stall_cnt <= '0;
      end else if (r_noc1_valid
                   && (r_stall_cnt != SW'(STALL_LIMIT_P))) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
        if (r_stall_cnt == SW'(STALL_LIMIT_P - 1))
          r_stall_err <= 1'b1;
      end
    end
  end

  assign req_ready       = r_req_ready;
  assign noc1_valid      = r_noc1_valid;
  assign noc1_data       = r_noc1_data;
  assign ila_msg1_valid  = r_ila_valid;
  assign ila_msg1_type   = r_type;
  assign ila_msg1_tag    = r_addr[39:14];
  assign ila_msg1_source = r_src;
  assign ila_msg1_data   = r_data0;
  assign issue           = r_issue;
  assign done            = !rst && w_hs && w_last;
  assign busy            = !w_idle;
  assign stall_err       = r_stall_err;

endmodule

// File: tb/tb_l2_noc1_req_driver.sv
// Directed bench for the NoC1 request driver.
// Inputs driven and outputs sampled on the falling edge.
module tb_l2_noc1_req_driver;

  localparam logic [13:0] CHIP = 14'h2A5B;
  localparam logic [7:0]  CX   = 8'h12;
  localparam logic [7:0]  CY   = 8'h34;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_type;
  logic [39:0] req_addr;
  logic [7:0]  req_mshrid;
  logic [5:0]  req_src;
  logic [1:0]  req_dcnt;
  logic [63:0] req_data0;
  logic [63:0] req_data1;
  logic [13:0] chipid;
  logic [7:0]  coreid_x;
  logic [7:0]  coreid_y;
  logic        noc1_valid;
  logic [63:0] noc1_data;
  logic        noc1_ready;
  logic        ila_msg1_valid;
  logic [7:0]  ila_msg1_type;
  logic [25:0] ila_msg1_tag;
  logic [5:0]  ila_msg1_source;
  logic [63:0] ila_msg1_data;
  logic        issue;
  logic        done;
  logic        busy;
  logic        stall_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_noc1_req_driver dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_type        (req_type),
    .req_addr        (req_addr),
    .req_mshrid      (req_mshrid),
    .req_src         (req_src),
    .req_dcnt        (req_dcnt),
    .req_data0       (req_data0),
    .req_data1       (req_data1),
    .chipid          (chipid),
    .coreid_x        (coreid_x),
    .coreid_y        (coreid_y),
    .noc1_valid      (noc1_valid),
    .noc1_data       (noc1_data),
    .noc1_ready      (noc1_ready),
    .ila_msg1_valid  (ila_msg1_valid),
    .ila_msg1_type   (ila_msg1_type),
    .ila_msg1_tag    (ila_msg1_tag),
    .ila_msg1_source (ila_msg1_source),
    .ila_msg1_data   (ila_msg1_data),
    .issue           (issue),
    .done            (done),
    .busy            (busy),
    .stall_err       (stall_err)
  );

  function automatic logic [63:0] e_hdr1(
    input logic [7:0] t, input logic [7:0] m, input logic [7:0] pl);
    logic [63:0] h;
    h = 64'd0;
    h[63:50] = CHIP;
    h[49:42] = CX;
    h[41:34] = CY;
    h[29:22] = pl;
    h[21:14] = t;
    h[13:6]  = m;
    return h;
  endfunction

  function automatic logic [63:0] e_hdr2(input logic [39:0] a);
    return {8'h00, a, 16'h0000};
  endfunction

  function automatic logic [63:0] e_hdr3();
    logic [63:0] h;
    h = 64'd0;
    h[63:50] = CHIP;
    h[49:42] = CX;
    h[41:34] = CY;
    return h;
  endfunction

  // Offers one request; returns at the falling edge of the HDR1 cycle.
  task automatic send(input logic [7:0] t, input logic [39:0] a,
                      input logic [7:0] m, input logic [5:0] s,
                      input logic [1:0] dc, input logic [63:0] d0,
                      input logic [63:0] d1);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_req_ready got=%b exp=1", req_ready);
    end
    req_type = t; req_addr = a; req_mshrid = m; req_src = s;
    req_dcnt = dc; req_data0 = d0; req_data1 = d1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, noc1_valid, ila_msg1_valid, issue, done, busy,
         stall_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=1000000",
        {req_ready, noc1_valid, ila_msg1_valid, issue, done, busy,
         stall_err});
    end
    checks++;
    if ({noc1_data, ila_msg1_tag, ila_msg1_type} !== 98'd0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0",
        {noc1_data, ila_msg1_tag, ila_msg1_type});
    end
    rst = 1'b0;
  endtask

  task automatic test_store();
    logic [63:0] e;
    noc1_ready = 1'b1;
    send(8'd2, 40'h12_3456_7800, 8'h5A, 6'd9, 2'd1,
         64'hDEAD_BEEF_0000_0001, 64'h0);
    e = e_hdr1(8'd2, 8'h5A, 8'd3);
    checks++;
    if (noc1_valid !== 1'b1 || noc1_data !== e || issue !== 1'b0) begin
      errors++;
      $display("FAIL store_hdr1 got=%b/%h/%b exp=1/%h/0",
        noc1_valid, noc1_data, issue, e);
    end
    checks++;
    if (noc1_data[29:22] !== 8'd3) begin
      errors++;
      $display("FAIL store_paylen got=%0d exp=3", noc1_data[29:22]);
    end
    @(negedge clk);
    e = e_hdr2(40'h12_3456_7800);
    checks++;
    if (noc1_data !== e || issue !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL store_hdr2 got=%h/%b/%b exp=%h/1/0",
        noc1_data, issue, done, e);
    end
    @(negedge clk);
    e = e_hdr3();
    checks++;
    if (noc1_data !== e || issue !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL store_hdr3 got=%h/%b/%b exp=%h/0/0",
        noc1_data, issue, done, e);
    end
    @(negedge clk);
    checks++;
    if (noc1_data !== 64'hDEAD_BEEF_0000_0001 || done !== 1'b1
        || noc1_valid !== 1'b1) begin
      errors++;
      $display("FAIL store_data0 got=%h/%b exp=deadbeef00000001/1",
        noc1_data, done);
    end
    @(negedge clk);
    checks++;
    if ({noc1_valid, req_ready, done, busy} !== 4'b0100) begin
      errors++;
      $display("FAIL store_end got=%b exp=0100",
        {noc1_valid, req_ready, done, busy});
    end
  endtask

  task automatic test_hdr2_stall();
    logic [63:0] e;
    noc1_ready = 1'b1;
    send(8'd15, 40'h00_0000_4000, 8'h01, 6'd3, 2'd2,
         64'h1111, 64'h2222);
    checks++;
    if (noc1_data !== e_hdr1(8'd15, 8'h01, 8'd4)) begin
      errors++;
      $display("FAIL hold_hdr1 got=%h", noc1_data);
    end
    @(negedge clk);
    e = e_hdr2(40'h00_0000_4000);
    checks++;
    if (noc1_data !== e) begin
      errors++;
      $display("FAIL hold_hdr2_first got=%h exp=%h", noc1_data, e);
    end
    noc1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (noc1_valid !== 1'b1 || noc1_data !== e || done !== 1'b0) begin
        errors++;
        $display("FAIL hold_hdr2_%0d got=%b/%h exp=1/%h",
          i, noc1_valid, noc1_data, e);
      end
    end
    noc1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (noc1_data !== e_hdr3()) begin
      errors++;
      $display("FAIL hold_hdr3 got=%h exp=%h", noc1_data, e_hdr3());
    end
    @(negedge clk);
    checks++;
    if (noc1_data !== 64'h1111 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_d0 got=%h/%b exp=1111/0", noc1_data, done);
    end
    @(negedge clk);
    checks++;
    if (noc1_data !== 64'h2222 || done !== 1'b1) begin
      errors++;
      $display("FAIL hold_d1 got=%h/%b exp=2222/1", noc1_data, done);
    end
    @(negedge clk);
    checks++;
    if (noc1_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_end got=%b%b exp=01", noc1_valid, req_ready);
    end
  endtask

  task automatic test_dcnt0();
    noc1_ready = 1'b1;
    send(8'd31, 40'h55_0000_0040, 8'h77, 6'd1, 2'd0,
         64'hAAAA, 64'hBBBB);
    checks++;
    if (noc1_data !== e_hdr1(8'd31, 8'h77, 8'd2)) begin
      errors++;
      $display("FAIL d0_hdr1 got=%h exp=%h",
        noc1_data, e_hdr1(8'd31, 8'h77, 8'd2));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (noc1_data !== e_hdr3() || done !== 1'b1) begin
      errors++;
      $display("FAIL d0_hdr3_done got=%h/%b exp=%h/1",
        noc1_data, done, e_hdr3());
    end
    @(negedge clk);
    checks++;
    if ({noc1_valid, req_ready, done} !== 3'b010) begin
      errors++;
      $display("FAIL d0_end got=%b exp=010",
        {noc1_valid, req_ready, done});
    end
  endtask

  task automatic test_addr_ila();
    logic [39:0] a;
    logic [25:0] tg;
    a  = 40'hAB_CDEF_1234;
    tg = a[39:14];
    noc1_ready = 1'b1;
    send(8'd2, a, 8'h42, 6'd37, 2'd3, 64'hC0FFEE, 64'hF00D);
    checks++;
    if (noc1_data[29:22] !== 8'd4) begin
      errors++;
      $display("FAIL clamp_paylen got=%0d exp=4", noc1_data[29:22]);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ila_msg1_valid !== 1'b1 || ila_msg1_tag !== tg
          || ila_msg1_type !== 8'd2 || ila_msg1_source !== 6'd37
          || ila_msg1_data !== 64'hC0FFEE) begin
        errors++;
        $display("FAIL ila_flit%0d got=%b/%h/%h/%h/%h exp=1/%h/02/25/c0ffee",
          c, ila_msg1_valid, ila_msg1_tag, ila_msg1_type,
          ila_msg1_source, ila_msg1_data, tg);
      end
      if (c == 1) begin
        checks++;
        if (noc1_data[55:16] !== a || noc1_data !== e_hdr2(a)) begin
          errors++;
          $display("FAIL addr_hdr2 got=%h exp=%h", noc1_data, e_hdr2(a));
        end
      end
      if (c == 4) begin
        checks++;
        if (noc1_data !== 64'hF00D || done !== 1'b1) begin
          errors++;
          $display("FAIL clamp_last got=%h/%b exp=f00d/1",
            noc1_data, done);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ila_msg1_valid !== 1'b0 || noc1_valid !== 1'b0) begin
      errors++;
      $display("FAIL ila_end got=%b%b exp=00", ila_msg1_valid, noc1_valid);
    end
  endtask

  task automatic test_stall_limit();
    noc1_ready = 1'b0;
    send(8'd14, 40'h01_0000_0000, 8'h09, 6'd2, 2'd0, 64'h0, 64'h0);
    repeat (63) @(negedge clk);
    checks++;
    if (stall_err !== 1'b0
        || noc1_data !== e_hdr1(8'd14, 8'h09, 8'd2)) begin
      errors++;
      $display("FAIL stall_63 got=%b/%h exp=0/hdr1", stall_err, noc1_data);
    end
    @(negedge clk);
    checks++;
    if (stall_err !== 1'b1 || noc1_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_64 got=%b%b%b exp=111",
        stall_err, noc1_valid, busy);
    end
    noc1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (noc1_data !== e_hdr2(40'h01_0000_0000) || issue !== 1'b1
        || stall_err !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume got=%h/%b/%b exp=hdr2/1/1",
        noc1_data, issue, stall_err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got=%b exp=1", done);
    end
    @(negedge clk);
    checks++;
    if ({stall_err, req_ready, noc1_valid} !== 3'b110) begin
      errors++;
      $display("FAIL stall_sticky got=%b exp=110",
        {stall_err, req_ready, noc1_valid});
    end
  endtask

  task automatic test_rst_mid();
    noc1_ready = 1'b1;
    send(8'd2, 40'h00_1234_0000, 8'h10, 6'd5, 2'd2, 64'h33, 64'h44);
    repeat (4) @(negedge clk);
    checks++;
    if (noc1_data !== 64'h44 || noc1_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got=%h/%b exp=44/1", noc1_data, noc1_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done_gate got=%b exp=0", done);
    end
    @(negedge clk);
    checks++;
    if ({noc1_valid, req_ready, done, busy, stall_err, ila_msg1_valid}
        !== 6'b010000) begin
      errors++;
      $display("FAIL rst_abort got=%b exp=010000",
        {noc1_valid, req_ready, done, busy, stall_err, ila_msg1_valid});
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; noc1_ready = 1'b1;
    req_type = '0; req_addr = '0; req_mshrid = '0; req_src = '0;
    req_dcnt = '0; req_data0 = '0; req_data1 = '0;
    chipid = CHIP; coreid_x = CX; coreid_y = CY;
    test_reset();
    test_store();
    test_hdr2_stall();
    test_dcnt0();
    test_addr_ila();
    test_stall_limit();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
